// File: rtl/countdown_timer.sv
// Seconds countdown for a two-digit seven-segment display. A prescaler turns
// the system clock into count steps; load/start/pause strobes come from game control.
module countdown_timer #(
  parameter int unsigned CLK_FREQ    = 50_000_000,
  parameter int unsigned TICK_CYCLES = CLK_FREQ,
  parameter int unsigned INIT_VALUE  = 30
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [4:0] i_load_val,
  input  logic       i_start,
  input  logic       i_pause,
  output logic [4:0] o_time,
  output logic       o_running,
  output logic       o_expired,
  output logic       o_done
);

  localparam int unsigned     PW         = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(TICK_CYCLES - 1);
  localparam logic [4:0]      INIT_TIME  = 5'(INIT_VALUE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    time_q, time_d;
  logic          done_q, done_d;
  logic          running_q, expired_q;

  // State, prescaler, count and flag registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      time_q    <= INIT_TIME;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      time_q    <= time_d;
      done_q    <= done_d;
      running_q <= (state_d == S_RUN);
      expired_q <= (state_d == S_DONE);
    end
  end

  // Next-state logic; load overrides every other strobe, pause beats a wrap
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    time_d  = time_q;
    done_d  = 1'b0;
    if (i_load) begin
      state_d = S_IDLE;
      presc_d = '0;
      time_d  = i_load_val;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start && (time_q != 5'd0)) begin
            state_d = S_RUN;
            presc_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RUN: begin
          if (i_pause) begin
            state_d = S_PAUSE;
          end else if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            time_d  = time_q - 5'd1;
            if (time_q == 5'd1) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_PAUSE: begin
          if (i_start) begin
            state_d = S_RUN;
          end else begin
            state_d = S_PAUSE;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
          presc_d = '0;
        end
      endcase
    end
  end

  assign o_time    = time_q;
  assign o_running = running_q;
  assign o_expired = expired_q;
  assign o_done    = done_q;

endmodule
